// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer owning the HI/LO registers
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic        StallReq,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [3:0] cnt;
    logic [31:0] thi, tlo;
    logic is_mul, is_div, go, sgn, neg_a, neg_b;
    logic [31:0] ua, ub, dv, uq, ur, q, r;
    logic [63:0] prod;
    assign is_mul = Start && (MDUOp == 4'd1 || MDUOp == 4'd2);
    assign is_div = Start && (MDUOp == 4'd3 || MDUOp == 4'd4);
    assign go = (state == IDLE) && (is_mul || is_div);
    assign sgn = (MDUOp == 4'd1) || (MDUOp == 4'd3);
    assign prod = sgn ? {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB} : {32'b0, SrcA} * {32'b0, SrcB};
    // Signed divide runs on magnitudes so 0x80000000 / -1 cannot overflow
    assign neg_a = sgn && SrcA[31];
    assign neg_b = sgn && SrcB[31];
    assign ua = neg_a ? -SrcA : SrcA;
    assign ub = neg_b ? -SrcB : SrcB;
    assign dv = (ub == 32'd0) ? 32'd1 : ub;
    assign uq = ua / dv;
    assign ur = ua % dv;
    assign q = (neg_a ^ neg_b) ? -uq : uq;
    assign r = neg_a ? -ur : ur;
    assign Busy = (state == RUN);
    assign StallReq = Start | Busy;
    assign MDUOut = (MDUOp == 4'd5) ? HI : (MDUOp == 4'd6) ? LO : 32'd0;
    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? (go ? RUN : IDLE) : ((cnt == 4'd1) ? IDLE : RUN);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= 4'd0;
            thi <= 32'd0;
            tlo <= 32'd0;
            HI <= 32'd0;
            LO <= 32'd0;
        end else begin
            state <= state_n;
            if (go) begin
                cnt <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                {thi, tlo} <= is_mul ? prod : (SrcB == 32'd0) ? {HI, LO} : {r, q};
            end else if (state == RUN) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    HI <= thi;
                    LO <= tlo;
                end
            end else begin
                if (MDUOp == 4'd7) HI <= SrcA;
                if (MDUOp == 4'd8) LO <= SrcA;
            end
        end
    end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide sequencer for the E stage of the pipelined MIPS core. It sits beside the ALU and owns the HI/LO registers. It accepts `mult`/`multu`/`div`/`divu`/`mthi`/`mtlo` from the E stage and models the fixed multiply and divide latencies with a busy counter. It raises a stall request so the hazard unit holds any later HI/LO user in D.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.
- `clk`  in  1  system clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `SrcA`  in  32  rs operand, forwarded value.
- `SrcB`  in  32  rt operand, forwarded value.
- `MDUOp`  in  4  operation code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO. Codes 9–15 behave as NONE.
- `Start`  in  1  one-cycle pulse, high only with MDUOp 1–4.
- `Busy`  out  1  registered; high while an operation is in flight.
- `StallReq`  out  1  combinational: `Start | Busy`.
- `HI`  out  32  architectural HI register.
- `LO`  out  32  architectural LO register.
- `MDUOut`  out  32  combinational: HI if MDUOp=MFHI, LO if MDUOp=MFLO, otherwise 0.

## Operation
- The controller has two states, IDLE and RUN, plus a counter `cnt` (4 bits, sized for max(MULT_CYCLES, DIV_CYCLES)). It also holds temporary registers `tHI` and `tLO`.
- Reset (`reset`=0 at an edge): state goes to IDLE, `cnt`=0, Busy=0, and HI, LO, `tHI`, `tLO` all go to 0. Reset overrides every other input and aborts an in-flight operation with no commit.
- IDLE with Start=1 and MDUOp in 1–4:
  - The result is computed from SrcA/SrcB on that edge into `tHI`/`tLO`.
  - `cnt` loads MULT_CYCLES for multiply or DIV_CYCLES for divide.
  - State goes to RUN and Busy goes to 1.
- RUN: `cnt` decrements each edge. On the edge where `cnt`=1, the controller commits HI←`tHI` and LO←`tLO`, Busy goes to 0, and state returns to IDLE.
- Start, MTHI and MTLO are ignored in RUN. Upstream stalls guarantee they are not issued then; the bench checks that they are ignored.
- In IDLE, MTHI sets HI←SrcA and MTLO sets LO←SrcA, with one-edge latency. These are ignored in RUN.
- Arithmetic rules:
  - MULT: {HI,LO} = signed 64-bit product of SrcA and SrcB.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = signed quotient, truncated toward zero. HI = remainder, which takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV with 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (SrcB=0, DIV or DIVU): the full busy sequence still runs, but the commit writes back the old HI/LO, so HI and LO are unchanged.
- Start=1 with MDUOp outside 1–4 is ignored.
- MFHI/MFLO return the committed HI/LO only. They never return `tHI`/`tLO`.

## Timing
- Start sampled high at edge E0:
  - Busy is high in the cycles after edges E0 through E(N−1), that is N cycles, where N is the op's cycle count.
  - HI/LO change at edge EN.
  - Busy is 0 in the cycle after EN.
- StallReq is high in the Start cycle and all N busy cycles, N+1 cycles in total.
- A new Start is accepted in the first cycle with Busy=0, so operations run back-to-back with no gap.
- MTHI/MTLO take effect at the edge where they are sampled. A following MFHI/MFLO in the next cycle sees the new value.
- Outputs after reset: Busy=0, StallReq=Start, HI=0, LO=0, MDUOut=0 unless MFHI/MFLO is selected.

## Test plan
- MULT, SrcA=0xFFFFFFFE (−2), SrcB=3 → Busy high for exactly 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA. MULTU on the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV, SrcA=−7 (0xFFFFFFF9), SrcB=2 → after 10 busy cycles, LO=0xFFFFFFFD and HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- MTHI 0x12345678, then DIV 5/0 → Busy for 10 cycles, then HI still 0x12345678 and LO unchanged. Also check DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- During a MULT busy window, pulse Start with DIV and issue MTLO 0xDEAD → both ignored. The MULT result commits on schedule and Busy falls at 5 cycles.
- Reset asserted (`reset`=0) at busy cycle 3 of a DIV → the next cycle shows Busy=0, HI=LO=0 and no later commit. A MULT issued immediately after the reset edge completes normally.
- Back-to-back MULT then MULTU, with the second Start in the first Busy=0 cycle → StallReq stays high continuously. Check MFLO (MDUOut) matches LO in each phase.
